// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// hands instructions to decode and redirects on taken jumps/branches.
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc_out,
    input  logic            jack,
    input  logic            je,
    input  logic [XLEN-1:0] jump_target,
    output logic            redirect_misaligned
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_DROP = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_tgt;
    logic [XLEN-1:0] r_pc_out;
    logic [31:0]     r_instr;
    logic            r_mis;
    logic            w_redir;
    logic [XLEN-1:0] w_target;

    assign w_redir  = jack & je;
    assign w_target = {jump_target[XLEN-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_REQ: begin
                if (w_redir && !imem_ack) begin
                    w_next = S_DROP;
                end else if (imem_ack && !w_redir) begin
                    w_next = S_OUT;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    w_next = S_REQ;
                end
            end
            S_OUT: begin
                if (w_redir || instr_ready) begin
                    w_next = S_REQ;
                end
            end
            default: w_next = S_REQ;
        endcase
    end

    // In S_DROP the stale request keeps its address; the redirect waits in r_tgt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_VECTOR;
            r_tgt    <= RESET_VECTOR;
            r_pc_out <= RESET_VECTOR;
            r_instr  <= '0;
            r_mis    <= 1'b0;
        end else begin
            r_mis <= w_redir & jump_target[1];
            unique case (r_state)
                S_REQ: begin
                    if (w_redir) begin
                        if (imem_ack) begin
                            r_pc <= w_target;
                        end else begin
                            r_tgt <= w_target;
                        end
                    end else if (imem_ack) begin
                        r_instr  <= imem_rdata;
                        r_pc_out <= r_pc;
                        r_pc     <= r_pc + XLEN'(4);
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        r_pc <= w_redir ? w_target : r_tgt;
                    end else if (w_redir) begin
                        r_tgt <= w_target;
                    end
                end
                S_OUT: begin
                    if (w_redir) begin
                        r_pc <= w_target;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        imem_req            = 1'b0;
        instr_valid         = 1'b0;
        imem_addr           = RESET_VECTOR;
        instr               = '0;
        pc_out              = RESET_VECTOR;
        redirect_misaligned = 1'b0;
        if (!rst) begin
            imem_addr           = r_pc;
            instr               = r_instr;
            pc_out              = r_pc_out;
            redirect_misaligned = r_mis;
            unique case (r_state)
                S_REQ:   imem_req = 1'b1;
                S_DROP:  imem_req = 1'b1;
                S_OUT:   instr_valid = 1'b1;
                default: imem_req = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a transaction-level model predicts request
// addresses, delivered instructions and misalignment pulses into queues.
module tb_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        jack;
    logic        je;
    logic [31:0] jump_target;
    logic        redirect_misaligned;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] addr;
        int          at;
    } req_e;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        int          at;
    } out_e;

    req_e q_addr[$];
    out_e q_out[$];
    int   q_mis[$];

    fetch_unit #(
        .XLEN(32),
        .RESET_VECTOR(RV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .pc_out(pc_out),
        .jack(jack),
        .je(je),
        .jump_target(jump_target),
        .redirect_misaligned(redirect_misaligned)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic fail(input string name, input logic [31:0] act,
                        input logic [31:0] req);
        failures++;
        $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    endtask

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) fail(name, act, req);
    endtask

    // ---------------- reference model + stimulus ----------------
    bit          s_busy;
    bit          s_poison;
    bit          s_hold;
    bit          s_after_rst;
    int          s_hold_from;
    int          s_req_at;
    int          s_lat;
    logic [31:0] s_nxt;
    logic [31:0] s_cur;

    logic [31:0] tgt_tbl [0:6];

    task automatic push_req(input logic [31:0] a, input int at);
        req_e e;
        e.addr = a;
        e.at   = at;
        q_addr.push_back(e);
        s_req_at = at;
    endtask

    task automatic push_out(input logic [31:0] p, input logic [31:0] d,
                            input int at);
        out_e e;
        e.pc  = p;
        e.ins = d;
        e.at  = at;
        q_out.push_back(e);
    endtask

    task automatic step(input bit r, input int p_redir, input int p_ready,
                        input int lat_lo, input int lat_hi);
        int          k;
        bit          redir;
        logic [31:0] tgt;
        @(negedge clk);
        rst = r;
        #1;
        k = int'($urandom % 100);
        jack = 1'b0;
        je   = 1'b0;
        if (k < p_redir) begin
            jack = 1'b1;
            je   = 1'b1;
        end else if (k < p_redir + 5) begin
            jack = 1'b1;
        end else if (k < p_redir + 10) begin
            je = 1'b1;
        end
        if ($urandom % 2 == 0) jump_target = tgt_tbl[$urandom % 7];
        else jump_target = $urandom;
        instr_ready = (int'($urandom % 100) < p_ready);
        imem_rdata  = $urandom;
        if (r) begin
            imem_ack = ($urandom % 2 == 0);
            q_addr.delete();
            q_out.delete();
            q_mis.delete();
            s_busy      = 1'b0;
            s_poison    = 1'b0;
            s_hold      = 1'b0;
            s_req_at    = -1;
            s_after_rst = 1'b1;
            s_nxt       = RV;
            return;
        end
        if (s_after_rst) begin
            s_after_rst = 1'b0;
            s_nxt = RV;
            push_req(RV, cyc);
        end
        if (s_req_at == cyc) begin
            s_busy   = 1'b1;
            s_poison = 1'b0;
            s_cur    = s_nxt;
            s_lat    = int'($urandom_range(lat_hi, lat_lo));
            s_req_at = -1;
        end
        if (s_busy) imem_ack = (s_lat == 0);
        else imem_ack = ($urandom % 4 == 0);
        if (s_busy && !imem_ack) s_lat--;
        redir = jack && je;
        tgt   = {jump_target[31:2], 2'b00};
        if (redir) begin
            s_nxt = tgt;
            if (jump_target[1]) q_mis.push_back(cyc + 1);
        end
        if (s_hold && cyc >= s_hold_from && (redir || instr_ready)) begin
            s_hold = 1'b0;
            push_req(s_nxt, cyc + 1);
        end
        if (s_busy && imem_ack) begin
            s_busy = 1'b0;
            if (s_poison || redir) begin
                push_req(s_nxt, cyc + 1);
            end else begin
                push_out(s_cur, imem_rdata, cyc + 1);
                s_nxt       = s_cur + 32'd4;
                s_hold      = 1'b1;
                s_hold_from = cyc + 1;
            end
        end else if (s_busy && redir) begin
            s_poison = 1'b1;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        bit          m_busy;
        bit          m_valid;
        bit          exp_mis;
        logic [31:0] m_addr;
        req_e        er;
        out_e        cur;
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_addr  = RV;
        cur.pc  = RV;
        cur.ins = '0;
        cur.at  = 0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                chk(!imem_req, "rst_req", 32'(imem_req), 32'd0);
                chk(imem_addr == RV, "rst_addr", imem_addr, RV);
                chk(!instr_valid, "rst_valid", 32'(instr_valid), 32'd0);
                chk(instr == 32'd0, "rst_instr", instr, 32'd0);
                chk(pc_out == RV, "rst_pc_out", pc_out, RV);
                chk(!redirect_misaligned, "rst_mis",
                    32'(redirect_misaligned), 32'd0);
                m_busy  = 1'b0;
                m_valid = 1'b0;
            end else begin
                chk(!(imem_req && instr_valid), "req_with_valid",
                    32'(instr_valid), 32'd0);
                chk(imem_addr[1:0] == 2'b00, "addr_align", imem_addr, 32'd0);
                while (q_addr.size() > 0 && q_addr[0].at < cyc) begin
                    er = q_addr.pop_front();
                    checks++;
                    fail("missing_req", 32'(imem_req), er.addr);
                end
                if (m_busy && !imem_req) begin
                    checks++;
                    fail("req_dropped", 32'd0, m_addr);
                    m_busy = 1'b0;
                end
                if (imem_req && !m_busy) begin
                    if (q_addr.size() == 0) begin
                        checks++;
                        fail("unexpected_req", imem_addr, 32'd0);
                        m_addr = imem_addr;
                    end else begin
                        er = q_addr.pop_front();
                        chk(er.at == cyc, "req_cycle", 32'(cyc), 32'(er.at));
                        m_addr = er.addr;
                    end
                    m_busy = 1'b1;
                end
                if (imem_req) begin
                    chk(imem_addr == m_addr, "req_addr", imem_addr, m_addr);
                    if (imem_ack) m_busy = 1'b0;
                end
                while (q_out.size() > 0 && q_out[0].at < cyc) begin
                    cur = q_out.pop_front();
                    checks++;
                    fail("missing_valid", 32'(instr_valid), cur.pc);
                end
                if (instr_valid && !m_valid) begin
                    if (q_out.size() == 0) begin
                        checks++;
                        fail("unexpected_valid", pc_out, 32'd0);
                        cur.pc  = pc_out;
                        cur.ins = instr;
                    end else begin
                        cur = q_out.pop_front();
                        chk(cur.at == cyc, "valid_cycle", 32'(cyc), 32'(cur.at));
                    end
                    m_valid = 1'b1;
                end else if (!instr_valid && m_valid) begin
                    checks++;
                    fail("valid_dropped", 32'd0, 32'd1);
                    m_valid = 1'b0;
                end
                if (instr_valid) begin
                    chk(instr == cur.ins, "instr", instr, cur.ins);
                    chk(pc_out == cur.pc, "pc_out", pc_out, cur.pc);
                    if (instr_ready || (jack && je)) m_valid = 1'b0;
                end
                while (q_mis.size() > 0 && q_mis[0] < cyc) void'(q_mis.pop_front());
                exp_mis = (q_mis.size() > 0 && q_mis[0] == cyc);
                if (exp_mis) void'(q_mis.pop_front());
                chk(redirect_misaligned == exp_mis, "misaligned",
                    32'(redirect_misaligned), 32'(exp_mis));
            end
        end
    end

    initial begin
        tgt_tbl[0] = 32'h0000_2000;
        tgt_tbl[1] = 32'h0000_1002;
        tgt_tbl[2] = 32'h0000_0300;
        tgt_tbl[3] = 32'h0000_0400;
        tgt_tbl[4] = 32'hFFFF_FFFC;
        tgt_tbl[5] = 32'h0000_1003;
        tgt_tbl[6] = 32'hFFFF_FFF8;
        rst         = 1'b1;
        jack        = 1'b0;
        je          = 1'b0;
        jump_target = '0;
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        s_busy      = 1'b0;
        s_poison    = 1'b0;
        s_hold      = 1'b0;
        s_after_rst = 1'b1;
        s_hold_from = 0;
        s_req_at    = -1;
        s_lat       = 0;
        s_nxt       = RV;
        s_cur       = RV;
        repeat (3) step(1'b1, 0, 0, 1, 1);
        // sequential fetch, memory answers one cycle after request
        repeat (20) step(1'b0, 0, 100, 1, 1);
        // decode stalls
        repeat (10) step(1'b0, 0, 0, 1, 1);
        repeat (10) step(1'b0, 0, 100, 0, 2);
        // redirect-heavy with slow memory to exercise dropped fetches
        repeat (400) step(1'b0, 30, 70, 2, 4);
        repeat (4000) begin
            step(($urandom % 120) == 0, 12, 60, 0, 3);
        end
        repeat (2) step(1'b0, 0, 100, 1, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
